// File: rtl/sprite_row_engine_if.sv
// Bundle of the scheduler handshake, sprite ROM port and line-buffer write port
// for one sprite_row_engine pipe.
interface sprite_row_engine_if #(
  parameter int unsigned SPRITE_W   = 16,
  parameter int unsigned ROW_BITS   = 4,
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned PIX_W      = 16,
  parameter int unsigned COL_W      = 10
);
  localparam int unsigned ROM_AW = FRAME_BITS + ROW_BITS + $clog2(SPRITE_W);

  logic                  start;
  logic [COL_W:0]        col_base;
  logic                  flip;
  logic                  scale2x;
  logic [FRAME_BITS-1:0] frame_id;
  logic [ROW_BITS-1:0]   row_off;
  logic [ROM_AW-1:0]     rom_addr;
  logic [PIX_W-1:0]      rom_q;
  logic [COL_W-1:0]      pixel_col;
  logic [PIX_W-1:0]      pixel_data;
  logic                  wren;
  logic                  busy;
  logic                  done;

  modport master (
    output start, col_base, flip, scale2x, frame_id, row_off, rom_q,
    input  rom_addr, pixel_col, pixel_data, wren, busy, done
  );

  modport slave (
    input  start, col_base, flip, scale2x, frame_id, row_off, rom_q,
    output rom_addr, pixel_col, pixel_data, wren, busy, done
  );
endinterface

// File: rtl/sprite_row_engine.sv
// Renders one sprite row into the line buffer: fetches texels, optionally mirrors
// or doubles them, drops transparent texels and clips to the visible line.
module sprite_row_engine #(
  parameter int unsigned SPRITE_W   = 16,
  parameter int unsigned ROW_BITS   = 4,
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned PIX_W      = 16,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned LINE_W     = 640,
  parameter int unsigned ROM_LAT    = 1
) (
  input logic                clk_i,
  input logic                reset_i,
  sprite_row_engine_if.slave bus_io
);
  localparam int unsigned IDX_W  = $clog2(SPRITE_W);
  localparam int unsigned ROM_AW = FRAME_BITS + ROW_BITS + IDX_W;
  localparam int unsigned KW     = IDX_W + 1;
  localparam int unsigned CW     = COL_W + 2;

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(SPRITE_W - 1);
  localparam logic [KW-1:0]    KLast1  = KW'(SPRITE_W - 1);
  localparam logic [KW-1:0]    KLast2  = KW'(2 * SPRITE_W - 1);
  localparam logic [CW-1:0]    LineWC  = CW'(LINE_W);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  dup_q, dup_d;
  logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
  logic [COL_W:0]        col_base_q;
  logic                  flip_q, scale_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [ROW_BITS-1:0]   row_q;
  logic [ROM_LAT-1:0]    vld_q;
  logic [KW-1:0]         k_q [ROM_LAT];

  logic          issue, accept, done, out_vld, in_line;
  logic [KW-1:0] slot_k, out_k, k_last, pos;
  logic [CW-1:0] col;

  assign slot_k  = scale_q ? {idx_q, dup_q} : {1'b0, idx_q};
  assign out_vld = vld_q[ROM_LAT-1];
  assign out_k   = k_q[ROM_LAT-1];
  assign k_last  = scale_q ? KLast2 : KLast1;
  assign pos     = flip_q ? (k_last - out_k) : out_k;
  // Sign-extended base plus unsigned offset: two's-complement sum in CW bits.
  assign col     = {col_base_q[COL_W], col_base_q} + {{(CW - KW){1'b0}}, pos};
  assign in_line = !col[CW-1] && (col < LineWC);
  assign done    = (state_q == StDrain) && out_vld && (out_k == k_last);
  assign accept  = bus_io.start && ((state_q == StIdle) || done);

  assign bus_io.rom_addr   = rom_addr_q;
  assign bus_io.pixel_col  = col[COL_W-1:0];
  assign bus_io.pixel_data = bus_io.rom_q;
  assign bus_io.wren       = out_vld && !bus_io.rom_q[PIX_W-1] && in_line;
  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.done       = done;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dup_d      = dup_q;
    rom_addr_d = rom_addr_q;
    issue      = 1'b0;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StFetch: begin
        issue = 1'b1;
        if (scale_q && !dup_q) begin
          dup_d = 1'b1;
        end else begin
          dup_d      = 1'b0;
          idx_d      = idx_q + 1'b1;
          rom_addr_d = {frame_q, row_q, idx_d};
          if (idx_q == IdxLast) state_d = StDrain;
        end
      end
      StDrain: if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A start in the done slot chains straight into the next row.
    if (accept) begin
      state_d    = StFetch;
      idx_d      = '0;
      dup_d      = 1'b0;
      rom_addr_d = {bus_io.frame_id, bus_io.row_off, {IDX_W{1'b0}}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      dup_q      <= 1'b0;
      rom_addr_q <= '0;
      col_base_q <= '0;
      flip_q     <= 1'b0;
      scale_q    <= 1'b0;
      frame_q    <= '0;
      row_q      <= '0;
      vld_q      <= '0;
      for (int i = 0; i < ROM_LAT; i++) k_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dup_q      <= dup_d;
      rom_addr_q <= rom_addr_d;
      if (accept) begin
        col_base_q <= bus_io.col_base;
        flip_q     <= bus_io.flip;
        scale_q    <= bus_io.scale2x;
        frame_q    <= bus_io.frame_id;
        row_q      <= bus_io.row_off;
      end
      // Slot tags ride alongside the ROM read so they line up with rom_q.
      vld_q[0] <= issue;
      k_q[0]   <= slot_k;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        k_q[i]   <= k_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_sprite_row_engine.sv
// Directed bench for sprite_row_engine: ROM_LAT=1 and ROM_LAT=2 instances with a
// texel-equals-index ROM model and write/done/busy logging relative to start.
module tb_sprite_row_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_row_engine_if bus ();
  sprite_row_engine_if bus2 ();

  sprite_row_engine #(.ROM_LAT(1)) u_dut (.clk_i(clk), .reset_i(reset), .bus_io(bus));
  sprite_row_engine #(.ROM_LAT(2)) u_dut2 (.clk_i(clk), .reset_i(reset), .bus_io(bus2));

  bit odd_tr;
  logic [15:0] rq1, rq2a, rq2b;

  function automatic logic [15:0] rom_f(input logic [15:0] a);
    logic [15:0] v;
    v = {12'h000, a[3:0]};
    if (odd_tr && a[0]) v[15] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    rq1  <= rom_f(bus.rom_addr);
    rq2a <= rom_f(bus2.rom_addr);
    rq2b <= rq2a;
  end
  assign bus.rom_q  = rq1;
  assign bus2.rom_q = rq2b;

  int t0 = 0, t0b = 0, rel1, rel2;
  int wcol[$], wdat[$], wcyc[$];
  int ndone, done_at, n2, first2, done2, ndone2;
  int addr_log [128];
  int busy_log [128];

  always @(negedge clk) begin
    rel1 = cyc - t0;
    if (rel1 >= 0 && rel1 < 128) begin
      addr_log[rel1] = int'(bus.rom_addr);
      busy_log[rel1] = int'(bus.busy);
    end
    if (bus.wren === 1'b1) begin
      wcol.push_back(int'(bus.pixel_col));
      wdat.push_back(int'(bus.pixel_data));
      wcyc.push_back(rel1);
    end
    if (bus.done === 1'b1) begin
      ndone++;
      done_at = rel1;
    end
    rel2 = cyc - t0b;
    if (bus2.wren === 1'b1) begin
      if (n2 == 0) first2 = rel2;
      n2++;
    end
    if (bus2.done === 1'b1) begin
      ndone2++;
      done2 = rel2;
    end
  end

  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wcol.delete();
    wdat.delete();
    wcyc.delete();
    ndone   = 0;
    done_at = -1;
    for (int i = 0; i < 128; i++) begin
      addr_log[i] = -1;
      busy_log[i] = -1;
    end
  endtask

  // Start pulse for one cycle, then scramble inputs to prove they were latched.
  task automatic launch(input int cb, input bit fl, input bit sc, input int fid, input int ro);
    bus.col_base = 11'(cb);
    bus.flip     = fl;
    bus.scale2x  = sc;
    bus.frame_id = 8'(fid);
    bus.row_off  = 4'(ro);
    bus.start    = 1'b1;
    step(1);
    bus.start    = 1'b0;
    bus.col_base = 11'd0;
    bus.flip     = ~fl;
    bus.scale2x  = ~sc;
    bus.frame_id = 8'hAA;
    bus.row_off  = 4'hF;
  endtask

  task automatic begin_row(input int cb, input bit fl, input bit sc);
    t0 = cyc;
    clear_logs();
    launch(cb, fl, sc, 3, 5);
  endtask

  task automatic wait_done(input int need);
    int i;
    i = 0;
    while (ndone < need && i < 200) begin
      step(1);
      i++;
    end
    if (ndone < need) check_eq("done_timeout", ndone, need);
    step(2);
  endtask

  initial begin
    reset        = 1'b1;
    odd_tr       = 1'b0;
    bus.start    = 1'b0;
    bus.col_base = '0;
    bus.flip     = 1'b0;
    bus.scale2x  = 1'b0;
    bus.frame_id = '0;
    bus.row_off  = '0;
    bus2.start    = 1'b0;
    bus2.col_base = '0;
    bus2.flip     = 1'b0;
    bus2.scale2x  = 1'b0;
    bus2.frame_id = '0;
    bus2.row_off  = '0;
    clear_logs();
    step(3);
    reset = 1'b0;
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_wren", int'(bus.wren), 0);
    check_eq("rst_addr", int'(bus.rom_addr), 0);
    check_eq("rst_col", int'(bus.pixel_col), 0);

    // Plain row.
    begin_row(100, 1'b0, 1'b0);
    wait_done(1);
    check_eq("plain_nwr", wcol.size(), 16);
    for (int j = 0; j < 16 && j < wcol.size(); j++) begin
      check_eq("plain_col", wcol[j], 100 + j);
      check_eq("plain_dat", wdat[j], j);
      check_eq("plain_cyc", wcyc[j], 2 + j);
      check_eq("plain_addr", addr_log[1 + j], 'h350 + j);
    end
    check_eq("plain_done", done_at, 17);
    check_eq("plain_busy17", busy_log[17], 1);
    check_eq("plain_busy18", busy_log[18], 0);

    // Mirrored row.
    begin_row(100, 1'b1, 1'b0);
    wait_done(1);
    check_eq("flip_nwr", wcol.size(), 16);
    for (int j = 0; j < 16 && j < wcol.size(); j++) begin
      check_eq("flip_col", wcol[j], 115 - j);
      check_eq("flip_dat", wdat[j], j);
    end
    check_eq("flip_done", done_at, 17);

    // Mirrored with odd texels transparent.
    odd_tr = 1'b1;
    begin_row(100, 1'b1, 1'b0);
    wait_done(1);
    odd_tr = 1'b0;
    check_eq("transp_nwr", wcol.size(), 8);
    for (int j = 0; j < 8 && j < wcol.size(); j++) begin
      check_eq("transp_col", wcol[j], 115 - 2 * j);
      check_eq("transp_dat", wdat[j], 2 * j);
    end
    check_eq("transp_done", done_at, 17);

    // Off-left clip.
    begin_row(-5, 1'b0, 1'b0);
    wait_done(1);
    check_eq("left_nwr", wcol.size(), 11);
    for (int j = 0; j < 11 && j < wcol.size(); j++) begin
      check_eq("left_col", wcol[j], j);
      check_eq("left_dat", wdat[j], 5 + j);
    end

    // Off-right clip, no wrap.
    begin_row(630, 1'b0, 1'b0);
    wait_done(1);
    check_eq("right_nwr", wcol.size(), 10);
    for (int j = 0; j < 10 && j < wcol.size(); j++) begin
      check_eq("right_col", wcol[j], 630 + j);
      check_eq("right_dat", wdat[j], j);
    end

    // 2x scale.
    begin_row(0, 1'b0, 1'b1);
    wait_done(1);
    check_eq("x2_nwr", wcol.size(), 32);
    for (int j = 0; j < 32 && j < wcol.size(); j++) begin
      check_eq("x2_col", wcol[j], j);
      check_eq("x2_dat", wdat[j], j / 2);
    end
    check_eq("x2_addr1", addr_log[1], 'h350);
    check_eq("x2_addr2", addr_log[2], 'h350);
    check_eq("x2_addr3", addr_log[3], 'h351);
    check_eq("x2_addr32", addr_log[32], 'h35F);
    check_eq("x2_done", done_at, 33);
    check_eq("x2_busy34", busy_log[34], 0);

    // 2x scale mirrored.
    begin_row(0, 1'b1, 1'b1);
    wait_done(1);
    check_eq("x2f_nwr", wcol.size(), 32);
    for (int j = 0; j < 32 && j < wcol.size(); j++) begin
      check_eq("x2f_col", wcol[j], 31 - j);
      check_eq("x2f_dat", wdat[j], j / 2);
    end

    // Back-to-back rows: second start lands in the done cycle.
    begin_row(100, 1'b0, 1'b0);
    step(16);
    bus.col_base = 11'd200;
    bus.flip     = 1'b0;
    bus.scale2x  = 1'b0;
    bus.frame_id = 8'd4;
    bus.row_off  = 4'd5;
    bus.start    = 1'b1;
    step(1);
    bus.start    = 1'b0;
    wait_done(2);
    check_eq("b2b_nwr", wcol.size(), 32);
    if (wcol.size() == 32) begin
      check_eq("b2b_lastA_cyc", wcyc[15], 17);
      check_eq("b2b_lastA_col", wcol[15], 115);
      check_eq("b2b_firstB_cyc", wcyc[16], 19);
      check_eq("b2b_firstB_col", wcol[16], 200);
      check_eq("b2b_lastB_col", wcol[31], 215);
    end
    check_eq("b2b_busy18", busy_log[18], 1);
    check_eq("b2b_addr18", addr_log[18], 'h450);
    check_eq("b2b_done", done_at, 34);
    check_eq("b2b_busy35", busy_log[35], 0);

    // Start mid-row is ignored.
    begin_row(100, 1'b0, 1'b0);
    step(4);
    bus.col_base = 11'd0;
    bus.frame_id = 8'd7;
    bus.start    = 1'b1;
    step(1);
    bus.start    = 1'b0;
    wait_done(1);
    check_eq("mid_nwr", wcol.size(), 16);
    if (wcol.size() == 16) begin
      check_eq("mid_col0", wcol[0], 100);
      check_eq("mid_col15", wcol[15], 115);
    end
    check_eq("mid_addr6", addr_log[6], 'h355);
    check_eq("mid_done", done_at, 17);
    check_eq("mid_busy18", busy_log[18], 0);
    step(20);
    check_eq("mid_ndone", ndone, 1);

    // Reset mid-row at cycle 8.
    begin_row(100, 1'b0, 1'b0);
    step(7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("rmid_wren", int'(bus.wren), 0);
    check_eq("rmid_busy", int'(bus.busy), 0);
    check_eq("rmid_done", int'(bus.done), 0);
    check_eq("rmid_addr", int'(bus.rom_addr), 0);
    step(25);
    check_eq("rmid_nodone", ndone, 0);

    // Reset and start together: start dropped.
    t0 = cyc;
    clear_logs();
    reset = 1'b1;
    launch(100, 1'b0, 1'b0, 3, 5);
    reset = 1'b0;
    check_eq("rst_start_busy", int'(bus.busy), 0);
    step(5);
    check_eq("rst_start_busy5", int'(bus.busy), 0);
    check_eq("rst_start_nwr", wcol.size(), 0);

    // ROM_LAT=2 instance.
    t0b = cyc;
    n2 = 0;
    ndone2 = 0;
    first2 = -1;
    done2 = -1;
    bus2.col_base = 11'd100;
    bus2.frame_id = 8'd3;
    bus2.row_off  = 4'd5;
    bus2.start    = 1'b1;
    step(1);
    bus2.start    = 1'b0;
    for (int i = 0; i < 100 && ndone2 == 0; i++) step(1);
    step(2);
    check_eq("lat2_first", first2, 3);
    check_eq("lat2_done", done2, 18);
    check_eq("lat2_nwr", n2, 16);
    check_eq("lat2_busy", int'(bus2.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
